// File: rtl/hex_disp_pkg.sv
// Shared types and the 7-segment glyph table for the HEX display arbiter.
// Segments are active-low, bit6=g .. bit0=a.
package hex_disp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Index 15 first: F, E, d, C, b, A, 9 .. 0
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/hex_digit_encode.sv
// One HEX digit: nibble to active-low segments, forced dark when blank is set.
module hex_digit_encode
   import hex_disp_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = blank ? SEG_BLANK : nibble_to_seg(nibble);
   end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the HEX0..HEX5 bank; snapshots the winner's value for DWELL cycles.
// Optional build macro HEX_LEADING_ZERO_BLANK_EN blanks leading-zero digits while showing.
module hex_display_arbiter
   import hex_disp_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int N_DIG = 6,
   parameter int DWELL = 50_000_000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_SRC-1:0]         req,
   input  logic [N_SRC*4*N_DIG-1:0] value,
   output logic [N_SRC-1:0]         grant,
   output logic [N_SRC-1:0]         done,
   output logic [$clog2(N_SRC)-1:0] owner,
   output logic [7*N_DIG-1:0]       HEX
);

   localparam int OW = $clog2(N_SRC);
   localparam int VW = 4 * N_DIG;
   localparam int CW = $clog2(DWELL + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);
   localparam logic [OW-1:0] LAST_SRC = OW'(N_SRC - 1);

   state_t          state_q, state_d;
   logic [OW-1:0]   ptr_q, ptr_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [VW-1:0]   snap_q, snap_d;
   logic            done_q, done_d;

   logic            win_found;
   logic [OW-1:0]   win_idx;
   logic [OW-1:0]   owner_next;
   logic            owner_req;
   logic [N_DIG-1:0] lead_zero;
   logic [N_DIG-1:0] dig_blank;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         snap_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         done_q  <= done_d;
      end
   end

   // First requester at or after the round-robin pointer
   always_comb begin
      int unsigned cand;
      cand      = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < N_SRC; k++) begin
         cand = (int'(ptr_q) + k) % N_SRC;
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = OW'(cand);
         end
      end
   end

   assign owner_next = (owner_q == LAST_SRC) ? '0 : owner_q + OW'(1);
   assign owner_req  = req[owner_q];

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (win_found) state_d = SHOW;
         SHOW: if (!owner_req || cnt_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next-state and registered-pulse control
   always_comb begin
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               owner_d = win_idx;
               snap_d  = value[int'(win_idx)*VW +: VW];
               cnt_d   = CNT_LOAD;
            end
         end
         SHOW: begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            // Release wins over completion when both happen in the same cycle
            if (!owner_req) begin
               ptr_d = owner_next;
            end else if (cnt_q == '0) begin
               ptr_d  = owner_next;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      grant = '0;
      done  = '0;
      if (state_q == SHOW) grant[owner_q] = 1'b1;
      if (done_q) done[owner_q] = 1'b1;
   end

   assign owner = owner_q;

`ifdef HEX_LEADING_ZERO_BLANK_EN
   always_comb begin
      logic all_zero_above;
      all_zero_above = 1'b1;
      lead_zero      = '0;
      for (int d = N_DIG - 1; d >= 1; d--) begin
         all_zero_above = all_zero_above && (snap_q[d*4 +: 4] == 4'h0);
         lead_zero[d]   = all_zero_above;
      end
   end
`else
   assign lead_zero = '0;
`endif

   always_comb begin
      for (int d = 0; d < N_DIG; d++) begin
         dig_blank[d] = (state_q != SHOW) || lead_zero[d];
      end
   end

   for (genvar d = 0; d < N_DIG; d++) begin : g_digit
      hex_digit_encode u_enc (
         .nibble (snap_q[d*4 +: 4]),
         .blank  (dig_blank[d]),
         .seg    (HEX[d*7 +: 7])
      );
   end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter with N_SRC=4, N_DIG=6, DWELL=4.
module tb_hex_display_arbiter;

   localparam int NS = 4;
   localparam int ND = 6;
   localparam int DW = 4;

   logic              clk;
   logic              reset_n;
   logic [NS-1:0]     req;
   logic [NS*4*ND-1:0] value;
   logic [NS-1:0]     grant;
   logic [NS-1:0]     done;
   logic [1:0]        owner;
   logic [7*ND-1:0]   HEX;

   hex_display_arbiter #(.N_SRC(NS), .N_DIG(ND), .DWELL(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .value   (value),
      .grant   (grant),
      .done    (done),
      .owner   (owner),
      .HEX     (HEX)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Glyphs straight from the segment map (active-low, g..a)
   logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   function automatic logic [41:0] exp_hex(input logic [23:0] v);
      logic [41:0] h;
      int top;
      top = 0;
      for (int d = 0; d < ND; d++) if (v[d*4 +: 4] != 4'h0) top = d;
      for (int d = 0; d < ND; d++) begin
         h[d*7 +: 7] = seg_ref[v[d*4 +: 4]];
`ifdef HEX_LEADING_ZERO_BLANK_EN
         if (d > top) h[d*7 +: 7] = 7'h7F;
`endif
      end
      return h;
   endfunction

   typedef struct {
      int          src;
      int          stamp;
      logic [41:0] hex;
   } ev_t;

   ev_t gq[$];
   ev_t dq[$];

   // Reference model: who holds the display and how many cycles of showing remain
   bit m_busy;
   int m_owner;
   int m_left;
   int m_ptr;

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_left = 0; m_ptr = 0;
      gq.delete();
      dq.delete();
   endtask

   // Called once inputs for the upcoming edge are settled
   task automatic model_step();
      ev_t e;
      int w;
      if (!m_busy) begin
         w = -1;
         for (int k = 0; k < NS; k++) begin
            if (w < 0 && req[(m_ptr + k) % NS]) w = (m_ptr + k) % NS;
         end
         if (w >= 0) begin
            m_busy  = 1;
            m_owner = w;
            m_left  = DW;
            e.src   = w;
            e.stamp = cyc + 1;
            e.hex   = exp_hex(value[w*24 +: 24]);
            gq.push_back(e);
         end
      end else if (!req[m_owner]) begin
         m_busy = 0;
         m_ptr  = (m_owner + 1) % NS;
      end else begin
         m_left--;
         if (m_left == 0) begin
            e.src   = m_owner;
            e.stamp = cyc + 1;
            e.hex   = '0;
            dq.push_back(e);
            m_busy = 0;
            m_ptr  = (m_owner + 1) % NS;
         end
      end
   endtask

   task automatic step(input logic [NS-1:0] r, input logic [NS*24-1:0] v);
      @(posedge clk);
      #1;
      req   = r;
      value = v;
      model_step();
   endtask

   // Monitor
   bit          mon_en = 0;
   logic [3:0]  prev_grant = '0;
   logic [41:0] cur_hex = '0;

   always @(negedge clk) begin
      ev_t e;
      if (mon_en) begin
         if (grant != 0 && prev_grant == 0) begin
            if (gq.size() == 0) begin
               chk(0, "grant_unexpected", 64'(grant), 64'h0);
            end else begin
               e = gq.pop_front();
               chk(grant == 4'(1 << e.src), "grant_onehot", 64'(grant), 64'(1 << e.src));
               chk(owner == 2'(e.src), "grant_owner", 64'(owner), 64'(e.src));
               chk(cyc == e.stamp, "grant_cycle", 64'(cyc), 64'(e.stamp));
               cur_hex = e.hex;
            end
         end
         if (grant != 0 && prev_grant != 0)
            chk(grant == prev_grant, "grant_switch", 64'(grant), 64'(prev_grant));
         if (grant != 0) chk(HEX == cur_hex, "hex_show", 64'(HEX), 64'(cur_hex));
         else chk(HEX == {ND{7'h7F}}, "hex_idle", 64'(HEX), 64'({ND{7'h7F}}));
         if (done != 0) begin
            if (dq.size() == 0) begin
               chk(0, "done_unexpected", 64'(done), 64'h0);
            end else begin
               e = dq.pop_front();
               chk(done == 4'(1 << e.src), "done_onehot", 64'(done), 64'(1 << e.src));
               chk(cyc == e.stamp, "done_cycle", 64'(cyc), 64'(e.stamp));
            end
         end
      end
      prev_grant = grant;
   end

   function automatic logic [23:0] rand_val();
      logic [23:0] v;
      v = 24'($urandom);
      return v & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
   endfunction

   initial begin
      logic [NS-1:0]    r;
      logic [NS*24-1:0] v;
      bit seen;

      reset_n = 1'b0;
      req     = '0;
      value   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk(grant == 0, "rst_grant", 64'(grant), 64'h0);
      chk(done == 0, "rst_done", 64'(done), 64'h0);
      chk(owner == 0, "rst_owner", 64'(owner), 64'h0);
      chk(HEX == {ND{7'h7F}}, "rst_hex", 64'(HEX), 64'({ND{7'h7F}}));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      mon_en  = 1;

      // Glyph and leading-zero check on 000A07
      v = '0;
      v[23:0] = 24'h000A07;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(4'b0001, v);
         @(negedge clk);
         if (grant[0]) seen = 1;
      end
      chk(seen, "a07_grant_seen", 64'(grant), 64'h1);
      chk(HEX[20:0] == {7'b0001000, 7'b1000000, 7'b1111000}, "a07_low_digits",
          64'(HEX[20:0]), 64'({7'b0001000, 7'b1000000, 7'b1111000}));
`ifdef HEX_LEADING_ZERO_BLANK_EN
      chk(HEX[41:21] == {3{7'h7F}}, "a07_high_digits", 64'(HEX[41:21]), 64'({3{7'h7F}}));
`else
      chk(HEX[41:21] == {3{7'b1000000}}, "a07_high_digits", 64'(HEX[41:21]),
          64'({3{7'b1000000}}));
`endif
      repeat (8) step(4'b0000, v);

      // Single source, then value changing mid-show
      v[23:0] = 24'h012345;
      repeat (10) step(4'b0001, v);
      for (int i = 0; i < 10; i++) begin
         v[23:0] = rand_val();
         step(4'b0001, v);
      end
      repeat (3) step(4'b0000, v);

      // All requesting: full rotation
      for (int s = 0; s < NS; s++) v[s*24 +: 24] = rand_val();
      repeat (26) step(4'b1111, v);
      repeat (3) step(4'b0000, v);

      // Early release by src1 after 2 cycles of ownership
      v[24 +: 24] = 24'hBEEF01;
      v[48 +: 24] = 24'h00C0DE;
      step(4'b0110, v);
      step(4'b0110, v);
      step(4'b0110, v);
      repeat (8) step(4'b0100, v);
      repeat (3) step(4'b0000, v);

      // Random traffic
      r = '0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = r ^ 4'(1 << $urandom_range(0, NS - 1));
         if ($urandom_range(0, 1) == 0) v[$urandom_range(0, NS - 1)*24 +: 24] = rand_val();
         step(r, v);
      end
      repeat (DW + 3) step(4'b0000, v);

      // Reset mid-show, then check the pointer restarts at 0
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(4'b0010, v);
         @(negedge clk);
         if (grant[1]) seen = 1;
      end
      chk(seen, "pre_reset_grant", 64'(grant), 64'h2);
      mon_en = 0;
      #1;
      reset_n = 1'b0;
      #1;
      chk(grant == 0, "midrst_grant", 64'(grant), 64'h0);
      chk(done == 0, "midrst_done", 64'(done), 64'h0);
      chk(HEX == {ND{7'h7F}}, "midrst_hex", 64'(HEX), 64'({ND{7'h7F}}));
      model_reset();
      req = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      req     = 4'b0101;
      model_step();
      mon_en = 1;
      repeat (DW + 2) step(4'b0101, v);
      repeat (DW + 4) step(4'b0000, v);

      @(negedge clk);
      chk(gq.size() == 0, "grants_outstanding", 64'(gq.size()), 64'h0);
      chk(dq.size() == 0, "dones_outstanding", 64'(dq.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
